// File: rtl/result_select_sequencer.sv
// result_select_sequencer
//   Classifies both IEEE-754 single operands at issue. Picks the special-case
//   outcome as four result-mux select codes plus the invalid and div-by-zero
//   flags. Carries that decision down a LATENCY-deep pipeline, in lockstep
//   with the arithmetic datapath. When the pipeline is full and not consumed,
//   every stage stalls together.
//
//   Select encodings:
//     sign     : 0 ZERO, 1 A, 2 B, 3 NB, 4 A_B, 5 A_NB, 6 RESULT
//     exponent : 0 ZEROS, 1 ONES, 2 RESULT
//     frac msb : 0 ZERO, 1 ONE, 2 RESULT
//     frac lsbs: 0 ZEROS, 1 A, 2 B, 3 RESULT
module result_select_sequencer #(
  parameter int unsigned LATENCY = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [1:0]  i_in_op,
  input  logic [31:0] i_in_a,
  input  logic [31:0] i_in_b,
  output logic        o_stage_enable,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [2:0]  o_sign_select,
  output logic [1:0]  o_exponent_select,
  output logic [1:0]  o_fraction_msb_select,
  output logic [1:0]  o_fraction_lsbs_select,
  output logic        o_out_invalid,
  output logic        o_out_div_by_zero,
  output logic [4:0]  o_in_flight
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] SIGN_ZERO   = 3'd0;
  localparam logic [2:0] SIGN_A      = 3'd1;
  localparam logic [2:0] SIGN_B      = 3'd2;
  localparam logic [2:0] SIGN_NB     = 3'd3;
  localparam logic [2:0] SIGN_A_B    = 3'd4;
  localparam logic [2:0] SIGN_A_NB   = 3'd5;
  localparam logic [2:0] SIGN_RESULT = 3'd6;

  localparam logic [1:0] EXP_ZEROS  = 2'd0;
  localparam logic [1:0] EXP_ONES   = 2'd1;
  localparam logic [1:0] EXP_RESULT = 2'd2;

  localparam logic [1:0] MSB_ZERO   = 2'd0;
  localparam logic [1:0] MSB_ONE    = 2'd1;
  localparam logic [1:0] MSB_RESULT = 2'd2;

  localparam logic [1:0] LSB_ZEROS  = 2'd0;
  localparam logic [1:0] LSB_A      = 2'd1;
  localparam logic [1:0] LSB_B      = 2'd2;
  localparam logic [1:0] LSB_RESULT = 2'd3;

  // Decision word: {sign[2:0], exp[1:0], msb[1:0], lsbs[1:0], invalid, div_by_zero}.
  // The all-zero word is the reset/idle value of every select and flag.
  localparam int DW = 11;

  logic w_a_exp_max, w_b_exp_max;
  logic w_a_zero, w_a_inf, w_a_nan, w_a_snan;
  logic w_b_zero, w_b_inf, w_b_nan, w_b_snan;
  logic w_is_addsub, w_eff_sub, w_invalid_op;
  logic w_advance, w_stage_enable, w_accept, w_consume;

  logic [2:0] w_sign;
  logic [1:0] w_exp, w_msb, w_lsb;
  logic       w_inv, w_dbz;
  logic [DW-1:0] w_dec;

  logic [LATENCY-1:0]         r_vld;
  logic [LATENCY-1:0][DW-1:0] r_dec;
  logic [4:0]                 r_in_flight;

  // Denormals are treated as zero: any operand with a zero exponent is ZERO.
  assign w_a_exp_max = (i_in_a[30:23] == 8'hFF);
  assign w_b_exp_max = (i_in_b[30:23] == 8'hFF);
  assign w_a_zero    = (i_in_a[30:23] == 8'h00);
  assign w_b_zero    = (i_in_b[30:23] == 8'h00);
  assign w_a_inf     = w_a_exp_max & (i_in_a[22:0] == 23'd0);
  assign w_b_inf     = w_b_exp_max & (i_in_b[22:0] == 23'd0);
  assign w_a_nan     = w_a_exp_max & (i_in_a[22:0] != 23'd0);
  assign w_b_nan     = w_b_exp_max & (i_in_b[22:0] != 23'd0);
  assign w_a_snan    = w_a_nan & ~i_in_a[22];
  assign w_b_snan    = w_b_nan & ~i_in_b[22];

  assign w_is_addsub = (i_in_op == OP_ADD) | (i_in_op == OP_SUB);
  assign w_eff_sub   = i_in_a[31] ^ i_in_b[31] ^ (i_in_op == OP_SUB);

  assign w_invalid_op =
      (w_is_addsub & w_a_inf & w_b_inf & w_eff_sub) |
      ((i_in_op == OP_MUL) & ((w_a_zero & w_b_inf) | (w_a_inf & w_b_zero))) |
      ((i_in_op == OP_DIV) & ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)));

  // Special-case decision at issue, first matching rule wins.
  always_comb begin
    w_sign = SIGN_RESULT;
    w_exp  = EXP_RESULT;
    w_msb  = MSB_RESULT;
    w_lsb  = LSB_RESULT;
    w_inv  = 1'b0;
    w_dbz  = 1'b0;
    if (w_a_nan) begin
      w_sign = SIGN_A;    w_exp = EXP_ONES; w_msb = MSB_ONE; w_lsb = LSB_A;
      w_inv  = w_a_snan | w_b_snan;
    end else if (w_b_nan) begin
      w_sign = SIGN_B;    w_exp = EXP_ONES; w_msb = MSB_ONE; w_lsb = LSB_B;
      w_inv  = w_b_snan;
    end else if (w_invalid_op) begin
      w_sign = SIGN_ZERO; w_exp = EXP_ONES; w_msb = MSB_ONE; w_lsb = LSB_ZEROS;
      w_inv  = 1'b1;
    end else if (w_is_addsub) begin
      if (w_a_inf) begin
        w_sign = SIGN_A;
        w_exp = EXP_ONES; w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end else if (w_b_inf) begin
        w_sign = (i_in_op == OP_ADD) ? SIGN_B : SIGN_NB;
        w_exp = EXP_ONES; w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end else if (w_a_zero & w_b_zero) begin
        w_sign = (i_in_op == OP_ADD) ? SIGN_A_B : SIGN_A_NB;
        w_exp = EXP_ZEROS; w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end
    end else if (i_in_op == OP_MUL) begin
      if (w_a_inf | w_b_inf) begin
        w_exp = EXP_ONES;  w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end else if (w_a_zero | w_b_zero) begin
        w_exp = EXP_ZEROS; w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end
    end else begin
      if (w_a_inf | w_b_zero) begin
        w_exp = EXP_ONES;  w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
        w_dbz = w_b_zero & ~w_a_inf;
      end else if (w_a_zero | w_b_inf) begin
        w_exp = EXP_ZEROS; w_msb = MSB_ZERO; w_lsb = LSB_ZEROS;
      end
    end
  end

  assign w_dec = {w_sign, w_exp, w_msb, w_lsb, w_inv, w_dbz};

  // One global advance strobe; flush blocks acceptance and consumption alike.
  assign w_advance      = ~r_vld[LATENCY-1] | i_out_ready;
  assign w_stage_enable = w_advance & ~i_flush;
  assign w_accept       = i_in_valid & w_stage_enable;
  assign w_consume      = r_vld[LATENCY-1] & i_out_ready & ~i_flush;

  // Valid chain and occupancy count; bubbles shift like real ops.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_vld       <= '0;
      r_in_flight <= 5'd0;
    end else begin
      if (w_stage_enable) begin
        r_vld[0] <= w_accept;
        for (int i = 1; i < int'(LATENCY); i++) r_vld[i] <= r_vld[i-1];
      end
      if (w_accept && !w_consume)      r_in_flight <= r_in_flight + 5'd1;
      else if (!w_accept && w_consume) r_in_flight <= r_in_flight - 5'd1;
    end
  end

  // Decision delay line; flush leaves it alone since stage_enable is low then.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dec <= '0;
    end else if (w_stage_enable) begin
      r_dec[0] <= w_dec;
      for (int i = 1; i < int'(LATENCY); i++) r_dec[i] <= r_dec[i-1];
    end
  end

  assign o_in_ready             = w_stage_enable;
  assign o_stage_enable         = w_stage_enable;
  assign o_out_valid            = r_vld[LATENCY-1];
  assign o_in_flight            = r_in_flight;
  assign o_sign_select          = r_dec[LATENCY-1][10:8];
  assign o_exponent_select      = r_dec[LATENCY-1][7:6];
  assign o_fraction_msb_select  = r_dec[LATENCY-1][5:4];
  assign o_fraction_lsbs_select = r_dec[LATENCY-1][3:2];
  assign o_out_invalid          = r_dec[LATENCY-1][1];
  assign o_out_div_by_zero      = r_dec[LATENCY-1][0];

endmodule

// File: tb/tb_result_select_sequencer.sv
// Testbench for result_select_sequencer: table-driven ops with hand-derived
// expected decisions, checked in order through a scoreboard queue.
module tb_result_select_sequencer;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3;
  localparam logic [2:0] S_ZERO = 3'd0, S_A = 3'd1, S_B = 3'd2, S_NB = 3'd3,
                         S_A_B = 3'd4, S_A_NB = 3'd5, S_RES = 3'd6;
  localparam logic [1:0] E_ZEROS = 2'd0, E_ONES = 2'd1, E_RES = 2'd2;
  localparam logic [1:0] M_ZERO = 2'd0, M_ONE = 2'd1, M_RES = 2'd2;
  localparam logic [1:0] L_ZEROS = 2'd0, L_A = 2'd1, L_B = 2'd2, L_RES = 2'd3;

  localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000, THREE = 32'h40400000;
  localparam logic [31:0] PINF = 32'h7F800000, NINF = 32'hFF800000;
  localparam logic [31:0] PZERO = 32'h00000000, NZERO = 32'h80000000;
  localparam logic [31:0] SNAN = 32'h7F800001, QNAN = 32'h7FC00000, DENORM = 32'h00000001;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, stage_enable, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [2:0]  sign_sel;
  logic [1:0]  exp_sel, msb_sel, lsb_sel;
  logic        out_inv, out_dbz;
  logic [4:0]  in_flight;

  int vectors = 0;
  int miscompares = 0;
  logic [10:0] cur_exp;
  logic [10:0] sb[$];
  logic [1:0]  t_op[$];
  logic [31:0] t_a[$], t_b[$];
  logic [10:0] t_exp[$];
  wire  [10:0] obs = {sign_sel, exp_sel, msb_sel, lsb_sel, out_inv, out_dbz};

  always #5 clk = ~clk;

  result_select_sequencer #(.LATENCY(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(in_op),
    .i_in_a(in_a), .i_in_b(in_b), .o_stage_enable(stage_enable),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_sign_select(sign_sel), .o_exponent_select(exp_sel),
    .o_fraction_msb_select(msb_sel), .o_fraction_lsbs_select(lsb_sel),
    .o_out_invalid(out_inv), .o_out_div_by_zero(out_dbz),
    .o_in_flight(in_flight)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [2:0] s, input logic [1:0] e,
                                     input logic [1:0] m, input logic [1:0] l,
                                     input logic inv, input logic dbz);
    return {s, e, m, l, inv, dbz};
  endfunction

  task automatic add_vec(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [10:0] e);
    t_op.push_back(op); t_a.push_back(a); t_b.push_back(b); t_exp.push_back(e);
  endtask

  // Scoreboard: push on accept, pop/compare on consume, discard on kill.
  always @(negedge clk) begin
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_val("unexpected_output", 32'(obs), 32'h7FF);
        else check_val("result", 32'(obs), 32'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Presents one op and returns at posedge+1 after it was accepted.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [10:0] e);
    logic acc;
    int n;
    in_op = op; in_a = a; in_b = b; cur_exp = e; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end
    if (!acc) check_val("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (in_flight != 5'd0 && n < 50) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    check_val("drain_in_flight", 32'(in_flight), 32'd0);
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = ADD; in_a = '0; in_b = '0; cur_exp = '0;

    add_vec(SUB, PINF, PINF,    mk(S_ZERO, E_ONES, M_ONE, L_ZEROS, 1, 0));
    add_vec(DIV, ONE, PZERO,    mk(S_RES, E_ONES, M_ZERO, L_ZEROS, 0, 1));
    add_vec(ADD, SNAN, ONE,     mk(S_A, E_ONES, M_ONE, L_A, 1, 0));
    add_vec(SUB, PZERO, PZERO,  mk(S_A_NB, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(ADD, ONE, QNAN,     mk(S_B, E_ONES, M_ONE, L_B, 0, 0));
    add_vec(ADD, QNAN, SNAN,    mk(S_A, E_ONES, M_ONE, L_A, 1, 0));
    add_vec(MUL, PZERO, PINF,   mk(S_ZERO, E_ONES, M_ONE, L_ZEROS, 1, 0));
    add_vec(ADD, PINF, ONE,     mk(S_A, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(SUB, ONE, PINF,     mk(S_NB, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(ADD, ONE, NINF,     mk(S_B, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(ADD, PZERO, NZERO,  mk(S_A_B, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(ADD, PINF, NINF,    mk(S_ZERO, E_ONES, M_ONE, L_ZEROS, 1, 0));
    add_vec(SUB, PINF, NINF,    mk(S_A, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(MUL, NINF, TWO,     mk(S_RES, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(MUL, PZERO, THREE,  mk(S_RES, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(DIV, PZERO, NZERO,  mk(S_ZERO, E_ONES, M_ONE, L_ZEROS, 1, 0));
    add_vec(DIV, PINF, NINF,    mk(S_ZERO, E_ONES, M_ONE, L_ZEROS, 1, 0));
    add_vec(DIV, PZERO, TWO,    mk(S_RES, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(DIV, TWO, PINF,     mk(S_RES, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(DIV, PINF, TWO,     mk(S_RES, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(DIV, PINF, PZERO,   mk(S_RES, E_ONES, M_ZERO, L_ZEROS, 0, 0));
    add_vec(ADD, DENORM, DENORM, mk(S_A_B, E_ZEROS, M_ZERO, L_ZEROS, 0, 0));
    add_vec(DIV, ONE, DENORM,   mk(S_RES, E_ONES, M_ZERO, L_ZEROS, 0, 1));
    add_vec(MUL, TWO, THREE,    mk(S_RES, E_RES, M_RES, L_RES, 0, 0));
    add_vec(ADD, ONE, PZERO,    mk(S_RES, E_RES, M_RES, L_RES, 0, 0));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_flight", 32'(in_flight), 32'd0);
    check_val("rst_selects", 32'(obs), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_stage_enable", 32'(stage_enable), 32'd1);
    @(posedge clk); #1;

    // Latency: ADD 1.0+2.0 shows out_valid 4 cycles after being presented.
    out_ready = 1'b1;
    issue(ADD, ONE, TWO, mk(S_RES, E_RES, M_RES, L_RES, 0, 0));
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check_val("latency", 32'(cyc), 32'd4);
    drain();

    // Back-to-back stream with the consumer always ready.
    for (int i = 0; i < t_op.size(); i++) issue(t_op[i], t_a[i], t_b[i], t_exp[i]);
    @(negedge clk);
    check_val("stream_in_flight", 32'(in_flight), 32'd4);
    @(posedge clk); #1;
    drain();

    // Stall: four ops with no consumer, then a fifth op held off.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(t_op[i], t_a[i], t_b[i], t_exp[i]);
    in_op = t_op[4]; in_a = t_a[4]; in_b = t_b[4]; cur_exp = t_exp[4]; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("stall_in_ready", 32'(in_ready), 32'd0);
      check_val("stall_in_flight", 32'(in_flight), 32'd4);
      check_val("stall_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("release_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("release_done", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    drain();

    // Flush with three ops in flight and a new op offered.
    for (int i = 0; i < 3; i++) issue(t_op[i], t_a[i], t_b[i], t_exp[i]);
    @(negedge clk);
    check_val("preflush_in_flight", 32'(in_flight), 32'd3);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_op = MUL; in_a = TWO; in_b = THREE;
    @(negedge clk);
    check_val("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("flush_in_flight", 32'(in_flight), 32'd0);
    check_val("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_val("flush_no_output", 32'(out_valid), 32'd0);
    check_val("flush_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // Reset mid-operation restores selects and flags.
    for (int i = 0; i < 4; i++) issue(t_op[i], t_a[i], t_b[i], t_exp[i]);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("midrst_out_valid", 32'(out_valid), 32'd0);
    check_val("midrst_in_flight", 32'(in_flight), 32'd0);
    check_val("midrst_selects", 32'(obs), 32'd0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
